// File: rtl/seg7_to_dec_monitor.sv
// Receive-side 7-segment monitor: filters an active-low segment bus until stable,
// decodes legal patterns to BCD and counts illegal ones.
module seg7_to_dec_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg_in,
    input  logic                 sample_en,
    output logic [3:0]           digit,
    output logic                 digit_valid,
    output logic                 pattern_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED, REJECT} state_t;

    state_t               state, state_n;
    logic [6:0]           seg_q, last_pat, last_n;
    logic [CNT_W-1:0]     cnt, cnt_n, cnt_inc;
    logic [3:0]           digit_n;
    logic                 dv_n, pe_n, locked_n;
    logic [ERR_CNT_W-1:0] err_n;
    logic                 dec_ok;
    logic [3:0]           dec_val;

    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'd0;
        case (seg_q)
            7'h40:   dec_val = 4'd0;
            7'h79:   dec_val = 4'd1;
            7'h24:   dec_val = 4'd2;
            7'h30:   dec_val = 4'd3;
            7'h19:   dec_val = 4'd4;
            7'h12:   dec_val = 4'd5;
            7'h02:   dec_val = 4'd6;
            7'h78:   dec_val = 4'd7;
            7'h00:   dec_val = 4'd8;
            7'h18:   dec_val = 4'd9;
            default: dec_ok  = 1'b0;
        endcase
    end

    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        last_n   = last_pat;
        digit_n  = digit;
        dv_n     = 1'b0;
        pe_n     = 1'b0;
        locked_n = locked;
        err_n    = err_count;
        if (sample_en) begin
            if (seg_q != last_pat) begin
                // Any change, including a glitch mid-settle, restarts qualification.
                last_n   = seg_q;
                cnt_n    = CNT_W'(1);
                locked_n = 1'b0;
                state_n  = SETTLE;
            end else if (state == SETTLE) begin
                cnt_n = cnt_inc;
                if (cnt_inc == CNT_W'(STABLE_CYCLES)) begin
                    if (dec_ok) begin
                        digit_n  = dec_val;
                        dv_n     = 1'b1;
                        locked_n = 1'b1;
                        state_n  = LOCKED;
                    end else if (seg_q == 7'h7F) begin
                        state_n = IDLE;
                    end else begin
                        pe_n    = 1'b1;
                        if (err_count != '1)
                            err_n = err_count + ERR_CNT_W'(1);
                        state_n = REJECT;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            seg_q       <= 7'h7F;
            last_pat    <= 7'h7F;
            cnt         <= '0;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            pattern_err <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_n;
            seg_q       <= seg_in;
            last_pat    <= last_n;
            cnt         <= cnt_n;
            digit       <= digit_n;
            digit_valid <= dv_n;
            pattern_err <= pe_n;
            locked      <= locked_n;
            err_count   <= err_n;
        end
    end

endmodule

// File: tb/tb_seg7_to_dec_monitor.sv
// Directed bench for seg7_to_dec_monitor; a second instance with a 2-bit
// error counter shares the stimulus to exercise saturation.
module tb_seg7_to_dec_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h7F;
    logic       sample_en = 1'b1;

    logic [3:0] digit, digit2;
    logic       digit_valid, digit_valid2;
    logic       pattern_err, pattern_err2;
    logic       locked, locked2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    int n_cmp = 0;
    int n_err = 0;
    int dv_cnt, pe_cnt, both_cnt;
    logic [3:0] dq[$];

    always #5 clk = ~clk;

    seg7_to_dec_monitor dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .sample_en(sample_en),
        .digit(digit), .digit_valid(digit_valid), .pattern_err(pattern_err),
        .locked(locked), .err_count(err_count)
    );

    seg7_to_dec_monitor #(.STABLE_CYCLES(4), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .sample_en(sample_en),
        .digit(digit2), .digit_valid(digit_valid2), .pattern_err(pattern_err2),
        .locked(locked2), .err_count(err_count2)
    );

    task automatic clr_counts();
        dv_cnt = 0; pe_cnt = 0; both_cnt = 0;
        dq.delete();
    endtask

    // Advance one edge and sample outputs 1 time unit later.
    task automatic step();
        @(posedge clk); #1;
        if (digit_valid) begin dv_cnt++; dq.push_back(digit); end
        if (pattern_err) pe_cnt++;
        if (digit_valid && pattern_err) both_cnt++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; seg_in = 7'h7F; sample_en = 1'b1;
        #12;
        rst_n = 1'b1;
        clr_counts();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; #2;
        n_cmp++; if (digit !== 4'd0) begin n_err++; $display("FAIL reset_digit: got %0d want 0", digit); end
        n_cmp++; if (digit_valid !== 1'b0) begin n_err++; $display("FAIL reset_dv: got %b want 0", digit_valid); end
        n_cmp++; if (pattern_err !== 1'b0) begin n_err++; $display("FAIL reset_pe: got %b want 0", pattern_err); end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_cmp++; if (err_count !== 8'd0) begin n_err++; $display("FAIL reset_err: got %0d want 0", err_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_blank();
        do_reset();
        repeat (20) step();
        n_cmp++; if (dv_cnt != 0) begin n_err++; $display("FAIL blank_dv: got %0d want 0", dv_cnt); end
        n_cmp++; if (pe_cnt != 0) begin n_err++; $display("FAIL blank_pe: got %0d want 0", pe_cnt); end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL blank_locked: got %b want 0", locked); end
        n_cmp++; if (err_count !== 8'd0) begin n_err++; $display("FAIL blank_err: got %0d want 0", err_count); end
    endtask

    task automatic test_single();
        do_reset();
        seg_in = 7'h30;
        repeat (4) step();
        n_cmp++; if (digit_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got %b want 0", digit_valid); end
        step();
        n_cmp++; if (digit_valid !== 1'b1) begin n_err++; $display("FAIL single_dv: got %b want 1", digit_valid); end
        n_cmp++; if (digit !== 4'd3) begin n_err++; $display("FAIL single_digit: got %0d want 3", digit); end
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL single_locked: got %b want 1", locked); end
        repeat (20) step();
        n_cmp++; if (dv_cnt != 1) begin n_err++; $display("FAIL single_count: got %0d want 1", dv_cnt); end
    endtask

    task automatic test_sweep();
        logic [6:0] codes [10];
        codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            seg_in = codes[i];
            repeat (8) step();
        end
        n_cmp++; if (dv_cnt != 10) begin n_err++; $display("FAIL sweep_count: got %0d want 10", dv_cnt); end
        for (int i = 0; i < 10 && i < dq.size(); i++) begin
            n_cmp++; if (dq[i] !== 4'(i)) begin n_err++; $display("FAIL sweep_digit%0d: got %0d want %0d", i, dq[i], i); end
        end
        n_cmp++; if (pe_cnt != 0) begin n_err++; $display("FAIL sweep_pe: got %0d want 0", pe_cnt); end
    endtask

    // Starts from the LOCKED "9" left by the sweep.
    task automatic test_glitch();
        clr_counts();
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL glitch_pre_locked: got %b want 1", locked); end
        seg_in = 7'h24;
        step();
        step();
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL glitch_locked_drop: got %b want 0", locked); end
        n_cmp++; if (digit !== 4'd9) begin n_err++; $display("FAIL glitch_digit_hold: got %0d want 9", digit); end
        seg_in = 7'h12;
        repeat (4) step();
        n_cmp++; if (dv_cnt != 0) begin n_err++; $display("FAIL glitch_no_two: got %0d want 0", dv_cnt); end
        step();
        n_cmp++; if (digit_valid !== 1'b1) begin n_err++; $display("FAIL glitch_dv: got %b want 1", digit_valid); end
        n_cmp++; if (digit !== 4'd5) begin n_err++; $display("FAIL glitch_digit: got %0d want 5", digit); end
        repeat (6) step();
        n_cmp++; if (dv_cnt != 1) begin n_err++; $display("FAIL glitch_count: got %0d want 1", dv_cnt); end
    endtask

    task automatic test_illegal();
        logic [6:0] bad [5];
        bad = '{7'h01, 7'h7E, 7'h55, 7'h2A, 7'h11};
        do_reset();
        seg_in = 7'h7C;
        repeat (5) step();
        n_cmp++; if (pattern_err !== 1'b1) begin n_err++; $display("FAIL illegal_pe: got %b want 1", pattern_err); end
        n_cmp++; if (digit_valid !== 1'b0) begin n_err++; $display("FAIL illegal_dv: got %b want 0", digit_valid); end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL illegal_locked: got %b want 0", locked); end
        n_cmp++; if (err_count !== 8'd1) begin n_err++; $display("FAIL illegal_err: got %0d want 1", err_count); end
        repeat (10) step();
        n_cmp++; if (pe_cnt != 1) begin n_err++; $display("FAIL illegal_repeat: got %0d want 1", pe_cnt); end
        for (int i = 0; i < 5; i++) begin
            seg_in = bad[i];
            repeat (6) step();
            seg_in = 7'h7F;
            repeat (6) step();
        end
        n_cmp++; if (pe_cnt != 6) begin n_err++; $display("FAIL illegal_pe_total: got %0d want 6", pe_cnt); end
        n_cmp++; if (err_count !== 8'd6) begin n_err++; $display("FAIL illegal_err_total: got %0d want 6", err_count); end
        n_cmp++; if (err_count2 !== 2'd3) begin n_err++; $display("FAIL illegal_err_sat: got %0d want 3", err_count2); end
        n_cmp++; if (dv_cnt != 0) begin n_err++; $display("FAIL illegal_no_dv: got %0d want 0", dv_cnt); end
    endtask

    // Capture edge is unqualified, then every other edge is qualified.
    task automatic qual_run(input logic [3:0] exp_digit, input string tag);
        sample_en = 1'b0;
        step();
        for (int k = 1; k <= 4; k++) begin
            sample_en = 1'b1;
            step();
            n_cmp++;
            if (digit_valid !== (k == 4)) begin
                n_err++; $display("FAIL %s_q%0d_dv: got %b want %b", tag, k, digit_valid, (k == 4));
            end
            sample_en = 1'b0;
            step();
        end
        n_cmp++; if (digit !== exp_digit) begin n_err++; $display("FAIL %s_digit: got %0d want %0d", tag, digit, exp_digit); end
        n_cmp++; if (digit_valid !== 1'b0) begin n_err++; $display("FAIL %s_dv_off: got %b want 0", tag, digit_valid); end
        n_cmp++; if (dv_cnt != 1) begin n_err++; $display("FAIL %s_count: got %0d want 1", tag, dv_cnt); end
    endtask

    task automatic test_qualifier_reset();
        do_reset();
        seg_in = 7'h79;
        qual_run(4'd1, "qual");
        // Second pattern: abandon mid-settle with an async reset.
        seg_in = 7'h18;
        sample_en = 1'b0; step();
        sample_en = 1'b1; step();
        sample_en = 1'b0; step();
        sample_en = 1'b1; step();
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL rst_pre_locked: got %b want 0", locked); end
        n_cmp++; if (digit !== 4'd1) begin n_err++; $display("FAIL rst_pre_digit: got %0d want 1", digit); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (digit !== 4'd0) begin n_err++; $display("FAIL rst_async_digit: got %0d want 0", digit); end
        n_cmp++; if (digit_valid !== 1'b0 || pattern_err !== 1'b0) begin n_err++; $display("FAIL rst_async_pulses: got %b%b want 00", digit_valid, pattern_err); end
        n_cmp++; if (locked !== 1'b0 || err_count !== 8'd0) begin n_err++; $display("FAIL rst_async_state: got %b/%0d want 0/0", locked, err_count); end
        #1 rst_n = 1'b1;
        clr_counts();
        qual_run(4'd9, "postrst");
    endtask

    initial begin
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        clr_counts();
        test_reset();
        test_blank();
        test_single();
        test_sweep();
        test_glitch();
        test_illegal();
        test_qualifier_reset();
        n_cmp++; if (both_cnt != 0) begin n_err++; $display("FAIL both_pulses: got %0d want 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
